// File: rtl/arm_pkg.sv
// Shared types for the ID/WB hazard scoreboard.
// Defines the slot record, the size limits and the DEPTH legality check.
package arm_pkg;

   localparam int unsigned SB_MAX_AW    = 8;
   localparam int unsigned SB_MAX_DEPTH = 8;

   typedef struct packed {
      logic                 valid;
      logic [SB_MAX_AW-1:0] dest;
      logic                 is_load;
   } sb_slot_t;

   localparam int unsigned SB_SLOT_W = $bits(sb_slot_t);

   function automatic bit sb_depth_ok(int unsigned d);
      return (d >= 1) && (d <= SB_MAX_DEPTH);
   endfunction

endpackage

// File: rtl/sb_slot.sv
// One scoreboard slot register with synchronous reset and flush.
// Ports: clk, rst, flush, slot_in (next record), slot_out (held record).
module sb_slot
   import arm_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [SB_SLOT_W-1:0] slot_in,
   output logic [SB_SLOT_W-1:0] slot_out
);

   sb_slot_t slot_d;
   sb_slot_t slot_q;

   always_comb begin
      slot_d = slot_in;
      if (flush) slot_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) slot_q <= '0;
      else     slot_q <= slot_d;
   end

   assign slot_out = slot_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destinations between ID and WB and raises a RAW stall.
// Ports: clk, rst, issue/source/dest info from ID, flush; hazard, issued,
// inflight (valid slot count) and stall_cnt (saturating hazard cycles).
module hazard_scoreboard
   import arm_pkg::*;
#(
   parameter int unsigned ADDRESS_LEN_REG_FILE = 4,
   parameter int unsigned DEPTH                = 2,
   parameter int unsigned FWD_EN               = 0,
   parameter int unsigned CNT_LEN              = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            issue_valid,
   input  logic [ADDRESS_LEN_REG_FILE-1:0] src1,
   input  logic [ADDRESS_LEN_REG_FILE-1:0] src2,
   input  logic                            two_src,
   input  logic [ADDRESS_LEN_REG_FILE-1:0] dest,
   input  logic                            wb_en,
   input  logic                            mem_r_en,
   input  logic                            flush,
   output logic                            hazard,
   output logic                            issued,
   output logic [$clog2(DEPTH+1)-1:0]      inflight,
   output logic [CNT_LEN-1:0]              stall_cnt
);

   localparam int unsigned IW = $clog2(DEPTH+1);

   if (!sb_depth_ok(DEPTH) ||
       (ADDRESS_LEN_REG_FILE > SB_MAX_AW))
   begin : g_bad_param
      $error("hazard_scoreboard: bad DEPTH/AW");
   end

   sb_slot_t slot_q  [DEPTH];
   sb_slot_t slot_in [DEPTH];

   logic [SB_MAX_AW-1:0] src1_x;
   logic [SB_MAX_AW-1:0] src2_x;
   logic [DEPTH-1:0]     m1;
   logic [DEPTH-1:0]     m2;

   logic [IW-1:0]      inflight_d, inflight_q;
   logic [CNT_LEN-1:0] stall_cnt_d, stall_cnt_q;

   assign src1_x = SB_MAX_AW'(src1);
   assign src2_x = SB_MAX_AW'(src2);

   always_comb begin
      m1 = '0;
      m2 = '0;
      for (int s = 0; s < DEPTH; s++) begin
         m1[s] = slot_q[s].valid &
                 (slot_q[s].dest == src1_x);
         m2[s] = two_src & slot_q[s].valid &
                 (slot_q[s].dest == src2_x);
      end
   end

   // With forwarding only a load in slot 0 cannot be bypassed.
   assign hazard = issue_valid &
      ((FWD_EN != 0) ?
         (slot_q[0].is_load & (m1[0] | m2[0])) :
         (|(m1 | m2)));

   assign issued = issue_valid & ~hazard;

   always_comb begin
      slot_in[0] = '0;
      if (issued && wb_en) begin
         slot_in[0].valid   = 1'b1;
         slot_in[0].dest    = SB_MAX_AW'(dest);
         slot_in[0].is_load = mem_r_en;
      end
      for (int i = 1; i < DEPTH; i++)
         slot_in[i] = slot_q[i-1];
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      sb_slot u_slot (
         .clk      (clk),
         .rst      (rst),
         .flush    (flush),
         .slot_in  (slot_in[g]),
         .slot_out (slot_q[g])
      );
   end

   // The oldest slot only retires; nothing reads its payload further.
   logic sb_unused;
   assign sb_unused = ^slot_q[DEPTH-1];

   always_comb begin
      inflight_d = '0;
      if (!flush) begin
         for (int i = 0; i < DEPTH; i++)
            inflight_d = inflight_d +
                         IW'(slot_in[i].valid);
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hazard && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         inflight_q  <= inflight_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign inflight  = inflight_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard.
// Four parameter variants share one stimulus set.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       iv, ts, we, mr, fl;
   logic [3:0] s1, s2, ds;

   logic        hz_a, is_a;
   logic [1:0]  inf_a;
   logic [15:0] sc_a;
   logic        hz_b, is_b;
   logic [1:0]  inf_b;
   logic [15:0] sc_b;
   logic        hz_c, is_c;
   logic [1:0]  inf_c;
   logic [3:0]  sc_c;
   logic        hz_d, is_d;
   logic [2:0]  inf_d;
   logic [15:0] sc_d;

   int pass_cnt = 0;
   int tot_cnt  = 0;
   logic [31:0] exp_q [$];
   logic [31:0] e;

   always #5 clk = ~clk;

   hazard_scoreboard u_a (
      .clk(clk), .rst(rst), .issue_valid(iv),
      .src1(s1), .src2(s2), .two_src(ts),
      .dest(ds), .wb_en(we), .mem_r_en(mr),
      .flush(fl), .hazard(hz_a), .issued(is_a),
      .inflight(inf_a), .stall_cnt(sc_a));

   hazard_scoreboard #(.FWD_EN(1)) u_b (
      .clk(clk), .rst(rst), .issue_valid(iv),
      .src1(s1), .src2(s2), .two_src(ts),
      .dest(ds), .wb_en(we), .mem_r_en(mr),
      .flush(fl), .hazard(hz_b), .issued(is_b),
      .inflight(inf_b), .stall_cnt(sc_b));

   hazard_scoreboard #(.CNT_LEN(4)) u_c (
      .clk(clk), .rst(rst), .issue_valid(iv),
      .src1(s1), .src2(s2), .two_src(ts),
      .dest(ds), .wb_en(we), .mem_r_en(mr),
      .flush(fl), .hazard(hz_c), .issued(is_c),
      .inflight(inf_c), .stall_cnt(sc_c));

   hazard_scoreboard #(.DEPTH(4)) u_d (
      .clk(clk), .rst(rst), .issue_valid(iv),
      .src1(s1), .src2(s2), .two_src(ts),
      .dest(ds), .wb_en(we), .mem_r_en(mr),
      .flush(fl), .hazard(hz_d), .issued(is_d),
      .inflight(inf_d), .stall_cnt(sc_d));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      iv = 0; s1 = 0; s2 = 0; ts = 0;
      ds = 0; we = 0; mr = 0; fl = 0;
   endtask

   task automatic do_reset;
      rst = 1;
      idle();
      tick();
      rst = 0;
   endtask

   task automatic test_reset;
      do_reset();
      iv = 1; s1 = 0; s2 = 0; ts = 1;
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(0);
      exp_q.push_back(0);
      #1;
      tot_cnt++; e = exp_q.pop_front();
      if (hz_a !== e[0])
         $display("FAIL rst_hazard got=%b exp=%b", hz_a, e[0]);
      else pass_cnt++;
      tot_cnt++; e = exp_q.pop_front();
      if (is_a !== e[0])
         $display("FAIL rst_issued got=%b exp=%b", is_a, e[0]);
      else pass_cnt++;
      tot_cnt++; e = exp_q.pop_front();
      if (inf_a !== e[1:0])
         $display("FAIL rst_inflight got=%0d exp=%0d", inf_a, e);
      else pass_cnt++;
      tot_cnt++; e = exp_q.pop_front();
      if (sc_a !== e[15:0])
         $display("FAIL rst_stall got=%0d exp=%0d", sc_a, e);
      else pass_cnt++;
      idle();
   endtask

   task automatic test_raw_stall;
      logic [2:0] eh, ei;
      logic [1:0] ef [3];
      eh = 3'b011; ei = 3'b100;
      ef = '{2'd1, 2'd1, 2'd0};
      do_reset();
      iv = 1; ds = 3; we = 1; s1 = 9; s2 = 10; ts = 0;
      exp_q.push_back(0);
      #1;
      tot_cnt++; e = exp_q.pop_front();
      if (hz_a !== e[0])
         $display("FAIL raw_first got=%b exp=%b", hz_a, e[0]);
      else pass_cnt++;
      tick();
      we = 0; ds = 0; s1 = 3;
      for (int c = 0; c < 3; c++) begin
         exp_q.push_back({31'b0, eh[c]});
         exp_q.push_back({31'b0, ei[c]});
         exp_q.push_back({30'b0, ef[c]});
         #1;
         tot_cnt++; e = exp_q.pop_front();
         if (hz_a !== e[0])
            $display("FAIL raw_hazard c%0d got=%b exp=%b",
                     c, hz_a, e[0]);
         else pass_cnt++;
         tot_cnt++; e = exp_q.pop_front();
         if (is_a !== e[0])
            $display("FAIL raw_issued c%0d got=%b exp=%b",
                     c, is_a, e[0]);
         else pass_cnt++;
         tot_cnt++; e = exp_q.pop_front();
         if (inf_a !== e[1:0])
            $display("FAIL raw_inflight c%0d got=%0d exp=%0d",
                     c, inf_a, e);
         else pass_cnt++;
         tick();
      end
      idle();
      exp_q.push_back(2);
      tot_cnt++; e = exp_q.pop_front();
      if (sc_a !== e[15:0])
         $display("FAIL raw_stall_cnt got=%0d exp=%0d", sc_a, e);
      else pass_cnt++;
   endtask

   task automatic test_fwd;
      do_reset();
      iv = 1; ds = 5; we = 1; mr = 0;
      tick();
      we = 0; ds = 0; s2 = 5; ts = 1;
      exp_q.push_back(0);
      #1;
      tot_cnt++; e = exp_q.pop_front();
      if (hz_b !== e[0])
         $display("FAIL fwd_alu got=%b exp=%b", hz_b, e[0]);
      else pass_cnt++;
      idle();
      tick(); tick(); tick();
      iv = 1; ds = 5; we = 1; mr = 1;
      tick();
      we = 0; mr = 0; ds = 0; s2 = 5; ts = 1;
      exp_q.push_back(1);
      exp_q.push_back(0);
      #1;
      tot_cnt++; e = exp_q.pop_front();
      if (hz_b !== e[0])
         $display("FAIL fwd_load_c0 got=%b exp=%b", hz_b, e[0]);
      else pass_cnt++;
      tick();
      tot_cnt++; e = exp_q.pop_front();
      if (hz_b !== e[0])
         $display("FAIL fwd_load_c1 got=%b exp=%b", hz_b, e[0]);
      else pass_cnt++;
      idle();
   endtask

   task automatic test_flush;
      do_reset();
      iv = 1; ds = 7; we = 1;
      tick();
      ds = 8; fl = 1; s1 = 7;
      exp_q.push_back(1);
      #1;
      tot_cnt++; e = exp_q.pop_front();
      if (hz_a !== e[0])
         $display("FAIL flush_preeval got=%b exp=%b", hz_a, e[0]);
      else pass_cnt++;
      tick();
      fl = 0; we = 0; ds = 0;
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(0);
      #1;
      tot_cnt++; e = exp_q.pop_front();
      if (inf_a !== e[1:0])
         $display("FAIL flush_inflight got=%0d exp=%0d", inf_a, e);
      else pass_cnt++;
      tot_cnt++; e = exp_q.pop_front();
      if (hz_a !== e[0])
         $display("FAIL flush_src7 got=%b exp=%b", hz_a, e[0]);
      else pass_cnt++;
      s1 = 8;
      #1;
      tot_cnt++; e = exp_q.pop_front();
      if (hz_a !== e[0])
         $display("FAIL flush_src8 got=%b exp=%b", hz_a, e[0]);
      else pass_cnt++;
      idle();
   endtask

   task automatic test_two_src;
      do_reset();
      iv = 1; ds = 4; we = 1;
      tick();
      we = 0; ds = 0; s1 = 1; s2 = 4; ts = 0;
      exp_q.push_back(0);
      exp_q.push_back(1);
      #1;
      tot_cnt++; e = exp_q.pop_front();
      if (hz_a !== e[0])
         $display("FAIL src2_unqual got=%b exp=%b", hz_a, e[0]);
      else pass_cnt++;
      ts = 1;
      #1;
      tot_cnt++; e = exp_q.pop_front();
      if (hz_a !== e[0])
         $display("FAIL src2_qual got=%b exp=%b", hz_a, e[0]);
      else pass_cnt++;
      idle();
   endtask

   task automatic test_sat;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         iv = 1; ds = 1; we = 1; s1 = 2;
         tick();
         we = 0; ds = 0; s1 = 1;
         tick();
         tick();
         if (k == 3) begin
            exp_q.push_back(8);
            tot_cnt++; e = exp_q.pop_front();
            if (sc_c !== e[3:0])
               $display("FAIL sat_mid got=%0d exp=%0d", sc_c, e);
            else pass_cnt++;
         end
      end
      idle();
      exp_q.push_back(15);
      exp_q.push_back(20);
      tot_cnt++; e = exp_q.pop_front();
      if (sc_c !== e[3:0])
         $display("FAIL sat_end got=%0d exp=%0d", sc_c, e);
      else pass_cnt++;
      tot_cnt++; e = exp_q.pop_front();
      if (sc_a !== e[15:0])
         $display("FAIL sat_wide got=%0d exp=%0d", sc_a, e);
      else pass_cnt++;
   endtask

   task automatic test_reset_full;
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         iv = 1; ds = 4'(k); we = 1;
         tick();
         if (k == 3) begin
            exp_q.push_back(3);
            tot_cnt++; e = exp_q.pop_front();
            if (inf_d !== e[2:0])
               $display("FAIL full_inf3 got=%0d exp=%0d", inf_d, e);
            else pass_cnt++;
         end
      end
      we = 0; ds = 0; s1 = 2;
      exp_q.push_back(4);
      exp_q.push_back(1);
      #1;
      tot_cnt++; e = exp_q.pop_front();
      if (inf_d !== e[2:0])
         $display("FAIL full_inf4 got=%0d exp=%0d", inf_d, e);
      else pass_cnt++;
      tot_cnt++; e = exp_q.pop_front();
      if (hz_d !== e[0])
         $display("FAIL full_hazard got=%b exp=%b", hz_d, e[0]);
      else pass_cnt++;
      rst = 1;
      tick();
      rst = 0;
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(0);
      #1;
      tot_cnt++; e = exp_q.pop_front();
      if (inf_d !== e[2:0])
         $display("FAIL postrst_inf got=%0d exp=%0d", inf_d, e);
      else pass_cnt++;
      tot_cnt++; e = exp_q.pop_front();
      if (sc_d !== e[15:0])
         $display("FAIL postrst_stall got=%0d exp=%0d", sc_d, e);
      else pass_cnt++;
      tot_cnt++; e = exp_q.pop_front();
      if (hz_d !== e[0])
         $display("FAIL postrst_hz2 got=%b exp=%b", hz_d, e[0]);
      else pass_cnt++;
      s1 = 4;
      #1;
      tot_cnt++; e = exp_q.pop_front();
      if (hz_d !== e[0])
         $display("FAIL postrst_hz4 got=%b exp=%b", hz_d, e[0]);
      else pass_cnt++;
      idle();
   endtask

   initial begin
      rst = 1;
      idle();
      test_reset();
      test_raw_stall();
      test_fwd();
      test_flush();
      test_two_src();
      test_sat();
      test_reset_full();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
